// File: rtl/cgm_switch_ctrl.sv
// Clock-source switch sequencer: arbitrates hw/sw requests, validates the target
// against clk_ok, drives the glitch-free mux select and acknowledges after a settle window.
module cgm_switch_ctrl #(
    parameter int unsigned SETTLE_CYC = 16,
    parameter int unsigned RESET_SEL  = 0
) (
    input  logic       clk_ref,
    input  logic       rst_clk,
    input  logic       hw_req,
    input  logic [1:0] hw_sel,
    output logic       hw_ack,
    output logic       hw_err,
    input  logic       sw_req,
    input  logic [1:0] sw_sel,
    output logic       sw_ack,
    output logic       sw_err,
    input  logic [2:0] clk_ok,
    input  logic       scan_mode,
    output logic [1:0] cgm_sel,
    output logic       switch_busy
);

    localparam int unsigned SEL_W = 2;
    localparam int unsigned CNT_W = 8;
    localparam logic [SEL_W-1:0] SEL_INVALID = SEL_W'(3);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_SWITCH,
        ST_SETTLE,
        ST_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_sel;
    logic [SEL_W-1:0]   w_sel_nxt;
    logic [SEL_W-1:0]   r_target;
    logic [SEL_W-1:0]   w_target_nxt;
    logic [SEL_W-1:0]   r_prev;
    logic [SEL_W-1:0]   w_prev_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_grant_sw;
    logic               w_grant_sw_nxt;
    logic               w_ack_nxt;
    logic               w_err_nxt;
    logic               r_hw_ack;
    logic               r_hw_err;
    logic               r_sw_ack;
    logic               r_sw_err;
    logic               r_busy;
    logic [3:0]         w_ok_ext;
    logic               w_target_ok;

    // Source 3 does not exist, so its clock-present flag reads as absent.
    assign w_ok_ext    = {1'b0, clk_ok};
    assign w_target_ok = w_ok_ext[r_target];

    // Next-state and next-register values; ack/err are produced on entry to DONE.
    always_comb begin
        w_state_nxt    = r_state;
        w_sel_nxt      = r_sel;
        w_target_nxt   = r_target;
        w_prev_nxt     = r_prev;
        w_cnt_nxt      = r_cnt;
        w_grant_sw_nxt = r_grant_sw;
        w_ack_nxt      = 1'b0;
        w_err_nxt      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!scan_mode && (hw_req || sw_req)) begin
                    w_grant_sw_nxt = !hw_req;
                    w_target_nxt   = hw_req ? hw_sel : sw_sel;
                    w_prev_nxt     = r_sel;
                    w_state_nxt    = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (r_target == SEL_INVALID || !w_target_ok) begin
                    w_ack_nxt   = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (r_target == r_sel) begin
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_state_nxt = ST_SWITCH;
                end
            end
            ST_SWITCH: begin
                w_sel_nxt   = r_target;
                w_cnt_nxt   = CNT_W'(SETTLE_CYC - 1);
                w_state_nxt = ST_SETTLE;
            end
            ST_SETTLE: begin
                // Losing the new source mid-settle falls back to the previous one.
                if (!w_target_ok) begin
                    w_sel_nxt   = r_prev;
                    w_ack_nxt   = 1'b1;
                    w_err_nxt   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else if (r_cnt == '0) begin
                    w_ack_nxt   = 1'b1;
                    w_state_nxt = ST_DONE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // State and registered outputs.
    always_ff @(posedge clk_ref or posedge rst_clk) begin
        if (rst_clk) begin
            r_state    <= ST_IDLE;
            r_sel      <= SEL_W'(RESET_SEL);
            r_target   <= '0;
            r_prev     <= '0;
            r_cnt      <= '0;
            r_grant_sw <= 1'b0;
            r_hw_ack   <= 1'b0;
            r_hw_err   <= 1'b0;
            r_sw_ack   <= 1'b0;
            r_sw_err   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_sel      <= w_sel_nxt;
            r_target   <= w_target_nxt;
            r_prev     <= w_prev_nxt;
            r_cnt      <= w_cnt_nxt;
            r_grant_sw <= w_grant_sw_nxt;
            r_hw_ack   <= w_ack_nxt && !w_grant_sw_nxt;
            r_hw_err   <= w_err_nxt && !w_grant_sw_nxt;
            r_sw_ack   <= w_ack_nxt && w_grant_sw_nxt;
            r_sw_err   <= w_err_nxt && w_grant_sw_nxt;
            r_busy     <= (w_state_nxt != ST_IDLE);
        end
    end

    assign hw_ack      = r_hw_ack;
    assign hw_err      = r_hw_err;
    assign sw_ack      = r_sw_ack;
    assign sw_err      = r_sw_err;
    assign cgm_sel     = r_sel;
    assign switch_busy = r_busy;

endmodule

// File: tb/tb_cgm_switch_ctrl.sv
// Self-checking bench for cgm_switch_ctrl: vector table, hand-written corner sequences
// and randomized requests checked against a transaction-level model.
module tb_cgm_switch_ctrl;

    localparam int SETTLE = 16;

    logic       clk_ref;
    logic       rst_clk;
    logic       hw_req;
    logic [1:0] hw_sel;
    logic       hw_ack;
    logic       hw_err;
    logic       sw_req;
    logic [1:0] sw_sel;
    logic       sw_ack;
    logic       sw_err;
    logic [2:0] clk_ok;
    logic       scan_mode;
    logic [1:0] cgm_sel;
    logic       switch_busy;

    int n_vec = 0;
    int n_err = 0;
    logic [1:0] m_sel;

    cgm_switch_ctrl #(
        .SETTLE_CYC (SETTLE),
        .RESET_SEL  (0)
    ) dut (
        .clk_ref     (clk_ref),
        .rst_clk     (rst_clk),
        .hw_req      (hw_req),
        .hw_sel      (hw_sel),
        .hw_ack      (hw_ack),
        .hw_err      (hw_err),
        .sw_req      (sw_req),
        .sw_sel      (sw_sel),
        .sw_ack      (sw_ack),
        .sw_err      (sw_err),
        .clk_ok      (clk_ok),
        .scan_mode   (scan_mode),
        .cgm_sel     (cgm_sel),
        .switch_busy (switch_busy)
    );

    initial clk_ref = 1'b0;
    always #5 clk_ref = ~clk_ref;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, required finish");
        $fatal(1);
    end

    typedef struct {
        logic       sw;
        logic [1:0] sel;
        logic [2:0] ok;
        logic       exp_err;
        int         exp_lat;
        logic [1:0] exp_sel;
    } vec_t;

    vec_t tbl [8];

    task automatic tick();
        @(posedge clk_ref);
        #1;
    endtask

    task automatic chk(input string name, input int cyc, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Transaction-level expectation from the switching rules.
    function automatic void predict(input logic [1:0] t, input logic [2:0] ok, input logic [1:0] cur,
                                    output logic err, output int lat, output logic [1:0] after);
        logic [3:0] okx;
        logic       bad;
        okx   = {1'b0, ok};
        bad   = !okx[t];
        err   = bad;
        lat   = (bad || t == cur) ? 2 : 3 + SETTLE;
        after = (bad || t == cur) ? cur : t;
    endfunction

    task automatic req_set(input logic who_sw, input logic [1:0] sel);
        if (who_sw) begin
            sw_req = 1'b1;
            sw_sel = sel;
        end else begin
            hw_req = 1'b1;
            hw_sel = sel;
        end
    endtask

    // Current cycle is the IDLE cycle in which the request is sampled (cycle 0).
    task automatic run_txn(input logic who_sw, input logic exp_err, input int exp_lat,
                           input logic [1:0] exp_after, input string tag, input int scan_cyc);
        logic [1:0] start;
        logic [1:0] exp_s;
        start = m_sel;
        for (int c = 1; c <= exp_lat; c++) begin
            tick();
            exp_s = (exp_lat > 2 && c >= 3) ? exp_after : start;
            chk({tag, "_busy"}, c, 32'(switch_busy), 32'd1);
            chk({tag, "_sel"}, c, 32'(cgm_sel), 32'(exp_s));
            if (who_sw) begin
                chk({tag, "_sw_ack"}, c, 32'(sw_ack), 32'(c == exp_lat));
                chk({tag, "_hw_ack"}, c, 32'(hw_ack), 32'd0);
            end else begin
                chk({tag, "_hw_ack"}, c, 32'(hw_ack), 32'(c == exp_lat));
                chk({tag, "_sw_ack"}, c, 32'(sw_ack), 32'd0);
            end
            if (c == scan_cyc) scan_mode = 1'b1;
            if (c == exp_lat) begin
                chk({tag, "_err"}, c, 32'(who_sw ? sw_err : hw_err), 32'(exp_err));
                chk({tag, "_other_err"}, c, 32'(who_sw ? hw_err : sw_err), 32'd0);
                if (who_sw) sw_req = 1'b0;
                else        hw_req = 1'b0;
            end
        end
        m_sel = exp_after;
        tick();
        chk({tag, "_idle_busy"}, 0, 32'(switch_busy), 32'd0);
        chk({tag, "_idle_acks"}, 0, 32'({hw_ack, sw_ack}), 32'd0);
        chk({tag, "_idle_sel"}, 0, 32'(cgm_sel), 32'(m_sel));
    endtask

    initial begin
        logic       e;
        int         l;
        logic [1:0] a;
        logic [2:0] ok;
        logic [1:0] hs;
        logic [1:0] ss;
        int         mode;

        tbl[0] = '{1'b1, 2'd1, 3'b111, 1'b0, 3 + SETTLE, 2'd1};
        tbl[1] = '{1'b1, 2'd3, 3'b111, 1'b1, 2,          2'd1};
        tbl[2] = '{1'b1, 2'd2, 3'b011, 1'b1, 2,          2'd1};
        tbl[3] = '{1'b0, 2'd1, 3'b111, 1'b0, 2,          2'd1};
        tbl[4] = '{1'b0, 2'd0, 3'b110, 1'b1, 2,          2'd1};
        tbl[5] = '{1'b0, 2'd2, 3'b100, 1'b0, 3 + SETTLE, 2'd2};
        tbl[6] = '{1'b1, 2'd0, 3'b111, 1'b0, 3 + SETTLE, 2'd0};
        tbl[7] = '{1'b0, 2'd3, 3'b000, 1'b1, 2,          2'd0};

        rst_clk   = 1'b1;
        hw_req    = 1'b0;
        hw_sel    = 2'd0;
        sw_req    = 1'b0;
        sw_sel    = 2'd0;
        clk_ok    = 3'b111;
        scan_mode = 1'b0;
        m_sel     = 2'd0;
        tick();
        tick();
        chk("rst_sel", 0, 32'(cgm_sel), 32'd0);
        chk("rst_busy", 0, 32'(switch_busy), 32'd0);
        chk("rst_acks", 0, 32'({hw_ack, sw_ack, hw_err, sw_err}), 32'd0);
        rst_clk = 1'b0;
        tick();
        chk("post_rst_busy", 0, 32'(switch_busy), 32'd0);

        // Vector table.
        for (int i = 0; i < 8; i++) begin
            clk_ok = tbl[i].ok;
            req_set(tbl[i].sw, tbl[i].sel);
            run_txn(tbl[i].sw, tbl[i].exp_err, tbl[i].exp_lat, tbl[i].exp_sel, $sformatf("tbl%0d", i), 0);
        end

        // Simultaneous requests: hw first, then the pending sw.
        clk_ok = 3'b111;
        req_set(1'b0, 2'd2);
        req_set(1'b1, 2'd1);
        run_txn(1'b0, 1'b0, 3 + SETTLE, 2'd2, "both_hw", 0);
        run_txn(1'b1, 1'b0, 3 + SETTLE, 2'd1, "both_sw", 0);

        // Back to source 0, then a 0->2 switch that loses clk_ok[2] in SETTLE cycle 5.
        req_set(1'b1, 2'd0);
        run_txn(1'b1, 1'b0, 3 + SETTLE, 2'd0, "to0", 0);
        req_set(1'b0, 2'd2);
        for (int c = 1; c <= 7; c++) begin
            tick();
            chk("rev_busy", c, 32'(switch_busy), 32'd1);
            chk("rev_sel", c, 32'(cgm_sel), (c >= 3) ? 32'd2 : 32'd0);
            chk("rev_ack", c, 32'({hw_ack, sw_ack}), 32'd0);
            if (c == 7) clk_ok = 3'b011;
        end
        tick();
        chk("rev_sel_back", 8, 32'(cgm_sel), 32'd0);
        chk("rev_hw_ack", 8, 32'(hw_ack), 32'd1);
        chk("rev_hw_err", 8, 32'(hw_err), 32'd1);
        chk("rev_sw_ack", 8, 32'(sw_ack), 32'd0);
        hw_req = 1'b0;
        tick();
        chk("rev_idle_busy", 9, 32'(switch_busy), 32'd0);
        chk("rev_idle_ack", 9, 32'(hw_ack), 32'd0);
        clk_ok = 3'b111;
        m_sel  = 2'd0;

        // scan_mode blocks grants but not an in-flight switch.
        scan_mode = 1'b1;
        req_set(1'b0, 2'd2);
        for (int c = 1; c <= 6; c++) begin
            tick();
            chk("scan_busy", c, 32'(switch_busy), 32'd0);
            chk("scan_sel", c, 32'(cgm_sel), 32'd0);
            chk("scan_ack", c, 32'(hw_ack), 32'd0);
        end
        scan_mode = 1'b0;
        run_txn(1'b0, 1'b0, 3 + SETTLE, 2'd2, "scan_mid", 5);
        req_set(1'b1, 2'd0);
        for (int c = 1; c <= 4; c++) begin
            tick();
            chk("scan2_busy", c, 32'(switch_busy), 32'd0);
            chk("scan2_sel", c, 32'(cgm_sel), 32'd2);
        end
        scan_mode = 1'b0;
        run_txn(1'b1, 1'b0, 3 + SETTLE, 2'd0, "scan_rel", 0);

        // Reset in the middle of SETTLE aborts without an ack.
        req_set(1'b1, 2'd1);
        for (int c = 1; c <= 5; c++) tick();
        chk("mid_sel", 5, 32'(cgm_sel), 32'd1);
        #2;
        rst_clk = 1'b1;
        sw_req  = 1'b0;
        #1;
        chk("arst_sel", 5, 32'(cgm_sel), 32'd0);
        chk("arst_busy", 5, 32'(switch_busy), 32'd0);
        tick();
        tick();
        rst_clk = 1'b0;
        m_sel   = 2'd0;
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("arst_noack", c, 32'({hw_ack, sw_ack}), 32'd0);
            chk("arst_idle_sel", c, 32'(cgm_sel), 32'd0);
        end

        // Randomized requests against the model.
        for (int k = 0; k < 40; k++) begin
            ok   = 3'($urandom | $urandom);
            mode = $urandom_range(0, 2);
            hs   = 2'($urandom);
            ss   = 2'($urandom);
            clk_ok = ok;
            if (mode != 1) req_set(1'b0, hs);
            if (mode != 0) req_set(1'b1, ss);
            if (mode != 1) begin
                predict(hs, ok, m_sel, e, l, a);
                run_txn(1'b0, e, l, a, $sformatf("rnd%0d_hw", k), 0);
            end
            if (mode != 0) begin
                predict(ss, ok, m_sel, e, l, a);
                run_txn(1'b1, e, l, a, $sformatf("rnd%0d_sw", k), 0);
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
